mips_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the non-pipelined MIPS datapath. It fetches each instruction over a request/acknowledge handshake, latches and decodes it, and drives the datapath control lines (`alu_src`, `alu_op`, `reg_write`, PC select/load) across fixed FETCH/DECODE/EXEC/WB phases. It also resolves branches from ALU flags, supports a halt handshake, counts retired instructions, and traps illegal opcodes and fetch timeouts.

---
 rtl/mips_ctrl_pkg.sv | 84 ++++++++
 rtl/mips_decoder.sv | 93 +++++++++
 rtl/mips_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_mips_seq_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer:
// opcodes, ALU/PC-select codes, FSM states and decode classes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLT   = 6'b001010;
  localparam logic [5:0] OP_BGT   = 6'b001011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_SLT = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_RS     = 2'd1,
    PC_JUMP   = 2'd2,
    PC_BRANCH = 2'd3
  } pc_sel_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  typedef enum logic [2:0] {
    C_ALU,
    C_ADDI,
    C_JR,
    C_J,
    C_BR,
    C_ILL
  } cls_e;

  typedef enum logic [1:0] {
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GT
  } br_e;

  typedef struct packed {
    cls_e    cls;
    alu_op_e alu_op;
    logic    alu_src;
    logic    wr_reg;
    br_e     br;
    logic    illegal;
  } dec_t;

  function automatic logic br_taken(
    input br_e  kind,
    input logic zero,
    input logic lt
  );
    logic t;
    unique case (kind)
      BR_EQ:   t = zero;
      BR_NE:   t = !zero;
      BR_LT:   t = lt;
      BR_GT:   t = !lt && !zero;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips_decoder.sv
// Combinational classifier for the latched instruction word.
// Unknown opcode/funct pairs come out as C_ILL with illegal set.
module mips_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_ir;

  assign op        = ir[31:26];
  assign fn        = ir[5:0];
  assign unused_ir = ^ir[25:6];

  always_comb begin
    dec         = '0;
    dec.cls     = C_ILL;
    dec.alu_op  = ALU_ADD;
    dec.br      = BR_EQ;
    dec.illegal = 1'b1;
    unique case (1'b1)
      (op == OP_RTYPE) && (fn == FN_ADD): begin
        dec.cls     = C_ALU;
        dec.alu_op  = ALU_ADD;
        dec.wr_reg  = 1'b1;
        dec.illegal = 1'b0;
      end
      (op == OP_RTYPE) && (fn == FN_SUB): begin
        dec.cls     = C_ALU;
        dec.alu_op  = ALU_SUB;
        dec.wr_reg  = 1'b1;
        dec.illegal = 1'b0;
      end
      (op == OP_RTYPE) && (fn == FN_AND): begin
        dec.cls     = C_ALU;
        dec.alu_op  = ALU_AND;
        dec.wr_reg  = 1'b1;
        dec.illegal = 1'b0;
      end
      (op == OP_RTYPE) && (fn == FN_SLT): begin
        dec.cls     = C_ALU;
        dec.alu_op  = ALU_SLT;
        dec.wr_reg  = 1'b1;
        dec.illegal = 1'b0;
      end
      (op == OP_RTYPE) && (fn == FN_JR): begin
        dec.cls     = C_JR;
        dec.illegal = 1'b0;
      end
      op == OP_ADDI: begin
        dec.cls     = C_ADDI;
        dec.alu_op  = ALU_ADD;
        dec.alu_src = 1'b1;
        dec.wr_reg  = 1'b1;
        dec.illegal = 1'b0;
      end
      op == OP_J: begin
        dec.cls     = C_J;
        dec.illegal = 1'b0;
      end
      op == OP_BEQ: begin
        dec.cls     = C_BR;
        dec.alu_op  = ALU_SUB;
        dec.br      = BR_EQ;
        dec.illegal = 1'b0;
      end
      op == OP_BNE: begin
        dec.cls     = C_BR;
        dec.alu_op  = ALU_SUB;
        dec.br      = BR_NE;
        dec.illegal = 1'b0;
      end
      op == OP_BLT: begin
        dec.cls     = C_BR;
        dec.alu_op  = ALU_SLT;
        dec.br      = BR_LT;
        dec.illegal = 1'b0;
      end
      op == OP_BGT: begin
        dec.cls     = C_BR;
        dec.alu_op  = ALU_SLT;
        dec.br      = BR_GT;
        dec.illegal = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MIPS datapath,
// with halt handshake, retire counter and fault trapping.
module mips_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             halt_req,
  output logic [31:0]      ir,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             pc_load,
  output logic [1:0]       pc_sel,
  output logic [CNT_W-1:0] retired,
  output logic             halted,
  output logic             fault
);

  localparam int TO_W = $clog2(FETCH_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  dec_t             dec;
  state_e           bound_st;

  mips_decoder u_dec (
    .ir  (ir_q),
    .dec (dec)
  );

  assign ir      = ir_q;
  assign retired = ret_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      to_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      to_q    <= to_d;
      ret_q   <= ret_d;
    end
  end

  // Outputs are Moore except branch pc_sel, which follows the live flags.
  always_comb begin
    imem_req  = 1'b0;
    alu_src   = 1'b0;
    alu_op    = ALU_ADD;
    reg_write = 1'b0;
    pc_load   = 1'b0;
    pc_sel    = PC_SEQ;
    halted    = 1'b0;
    fault     = 1'b0;
    unique case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        alu_src = dec.alu_src;
        alu_op  = dec.alu_op;
        unique case (dec.cls)
          C_JR: begin
            pc_load = 1'b1;
            pc_sel  = PC_RS;
          end
          C_J: begin
            pc_load = 1'b1;
            pc_sel  = PC_JUMP;
          end
          C_BR: begin
            pc_load = 1'b1;
            pc_sel  = br_taken(dec.br, alu_zero, alu_lt)
                      ? PC_BRANCH : PC_SEQ;
          end
          default: begin
          end
        endcase
      end
      S_WB: begin
        alu_src   = dec.alu_src;
        alu_op    = dec.alu_op;
        reg_write = 1'b1;
        pc_load   = 1'b1;
        pc_sel    = PC_SEQ;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: begin
      end
    endcase
  end

  assign bound_st = halt_req ? S_HALT : S_FETCH;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    to_d    = to_q;
    ret_d   = ret_q + CNT_W'(pc_load);
    unique case (state_q)
      S_IDLE: state_d = bound_st;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          to_d    = '0;
          state_d = S_DECODE;
        end else begin
          to_d = to_q + 1'b1;
          if (to_q == TO_W'(FETCH_TIMEOUT - 1)) begin
            state_d = S_FAULT;
          end
        end
      end
      S_DECODE: state_d = dec.illegal ? S_FAULT : S_EXEC;
      S_EXEC:   state_d = dec.wr_reg ? S_WB : bound_st;
      S_WB:     state_d = bound_st;
      S_HALT: begin
        if (!halt_req) begin
          state_d = S_FETCH;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Randomized self-checking bench for mips_seq_ctrl against an
// instruction-level reference model.
module tb_mips_seq_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          alu_zero = 1'b0;
  logic          alu_lt = 1'b0;
  logic          halt_req = 1'b0;
  logic [31:0]   ir;
  logic          alu_src;
  logic [1:0]    alu_op;
  logic          reg_write;
  logic          pc_load;
  logic [1:0]    pc_sel;
  logic [CW-1:0] retired;
  logic          halted;
  logic          fault;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0;

  mips_seq_ctrl #(.CNT_W(CW), .FETCH_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .alu_zero   (alu_zero),
    .alu_lt     (alu_lt),
    .halt_req   (halt_req),
    .ir         (ir),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .pc_load    (pc_load),
    .pc_sel     (pc_sel),
    .retired    (retired),
    .halted     (halted),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Instruction-level reference: what one instruction should do.
  task automatic model(
    input  logic [31:0] ins,
    input  bit          z,
    input  bit          l,
    output bit          legal,
    output bit          wr,
    output logic [1:0]  aop,
    output bit          asrc,
    output logic [1:0]  psel
  );
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    legal = 1; wr = 0; aop = 0; asrc = 0; psel = 0;
    if (op == 6'h00) begin
      case (fn)
        6'h20:   begin wr = 1; aop = 2'd0; end
        6'h22:   begin wr = 1; aop = 2'd1; end
        6'h24:   begin wr = 1; aop = 2'd2; end
        6'h2a:   begin wr = 1; aop = 2'd3; end
        6'h08:   psel = 2'd1;
        default: legal = 0;
      endcase
    end else begin
      case (op)
        6'h08: begin wr = 1; asrc = 1; end
        6'h02: psel = 2'd2;
        6'h04: begin aop = 2'd1; psel = z ? 2'd3 : 2'd0; end
        6'h05: begin aop = 2'd1; psel = !z ? 2'd3 : 2'd0; end
        6'h0a: begin aop = 2'd3; psel = l ? 2'd3 : 2'd0; end
        6'h0b: begin aop = 2'd3; psel = (!l && !z) ? 2'd3 : 2'd0; end
        default: legal = 0;
      endcase
    end
  endtask

  function automatic logic [31:0] gen(input bit allow_ill);
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, allow_ill ? 11 : 10);
    case (k)
      0:  begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
      1:  begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
      2:  begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
      3:  begin w[31:26] = 6'h00; w[5:0] = 6'h2a; end
      4:  begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      5:  w[31:26] = 6'h08;
      6:  w[31:26] = 6'h02;
      7:  w[31:26] = 6'h04;
      8:  w[31:26] = 6'h05;
      9:  w[31:26] = 6'h0a;
      10: w[31:26] = 6'h0b;
      default: begin
        if ($urandom_range(0, 1) == 1) begin
          w[31:26] = 6'h00; w[5:0] = 6'h21;
        end else begin
          w[31:26] = 6'h3f;
        end
      end
    endcase
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; halt_req = 1'b0;
    #1;
    checks++;
    if ({imem_req, alu_src, alu_op, reg_write, pc_load, pc_sel,
         halted, fault, retired, ir} !== '0) begin
      failures++;
      $display("FAIL rst_outputs req=%b rw=%b pl=%b f=%b ret=%0d ir=%h exp=all0",
               imem_req, reg_write, pc_load, fault, retired, ir);
    end
    @(negedge clk);
    reset = 1'b1;
    exp_ret = 0;
    #1;
    checks++;
    if ({imem_req, reg_write, pc_load, halted, fault, retired} !== '0) begin
      failures++;
      $display("FAIL idle_outputs req=%b pl=%b h=%b f=%b ret=%0d exp=all0",
               imem_req, pc_load, halted, fault, retired);
    end
    @(negedge clk);
  endtask

  // Runs one instruction starting at a FETCH negedge; returns at the
  // next FETCH negedge, or in FAULT for an illegal word.
  task automatic do_instr(
    input logic [31:0] ins,
    input int          dly,
    input bit          z,
    input bit          l,
    input bit          hreq
  );
    bit legal, wr, asrc;
    logic [1:0] aop, psel;
    model(ins, z, l, legal, wr, aop, asrc, psel);
    for (int k = 0; k < dly; k++) begin
      imem_ack = 1'b0; imem_rdata = $urandom;
      checks++;
      if ({imem_req, fault} !== 2'b10) begin
        failures++;
        $display("FAIL fetch_wait k=%0d req=%b fault=%b exp=1,0", k, imem_req, fault);
      end
      @(negedge clk);
    end
    checks++;
    if ({imem_req, pc_load, reg_write, halted} !== 4'b1000) begin
      failures++;
      $display("FAIL fetch_out req=%b pl=%b rw=%b h=%b exp=1000",
               imem_req, pc_load, reg_write, halted);
    end
    imem_ack = 1'b1; imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'($urandom); imem_rdata = $urandom;
    alu_zero = z; alu_lt = l; halt_req = hreq;
    checks++;
    if (ir !== ins || {imem_req, reg_write, pc_load, alu_src,
                       alu_op, pc_sel} !== '0) begin
      failures++;
      $display("FAIL decode ir=%h exp=%h rw=%b pl=%b req=%b", ir, ins,
               reg_write, pc_load, imem_req);
    end
    @(negedge clk);
    if (!legal) begin
      checks++;
      if ({fault, imem_req, pc_load, reg_write, halted} !== 5'b10000 ||
          retired !== CW'(exp_ret)) begin
        failures++;
        $display("FAIL illegal_trap f=%b pl=%b ret=%0d exp f=1 ret=%0d",
                 fault, pc_load, retired, exp_ret);
      end
      imem_ack = 1'b0; halt_req = 1'b0;
      return;
    end
    checks++;
    if ({alu_src, alu_op, reg_write, pc_load, pc_sel, imem_req} !==
        {asrc, aop, 1'b0, !wr, (wr ? 2'b00 : psel), 1'b0} || ir !== ins) begin
      failures++;
      $display("FAIL exec ins=%h src=%b op=%0d rw=%b pl=%b sel=%0d exp src=%b op=%0d pl=%b sel=%0d",
               ins, alu_src, alu_op, reg_write, pc_load, pc_sel,
               asrc, aop, !wr, (wr ? 2'b00 : psel));
    end
    if (wr) begin
      alu_zero = 1'($urandom); alu_lt = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({alu_src, alu_op, reg_write, pc_load, pc_sel} !==
          {asrc, aop, 1'b1, 1'b1, 2'b00}) begin
        failures++;
        $display("FAIL wb ins=%h src=%b op=%0d rw=%b pl=%b sel=%0d exp src=%b op=%0d rw=1 pl=1 sel=0",
                 ins, alu_src, alu_op, reg_write, pc_load, pc_sel, asrc, aop);
      end
    end
    exp_ret = (exp_ret + 1) % (1 << CW);
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if ({imem_req, halted, reg_write, pc_load} !== {!hreq, hreq, 2'b00} ||
        retired !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL boundary req=%b h=%b ret=%0d exp req=%b h=%b ret=%0d",
               imem_req, halted, retired, !hreq, hreq, exp_ret);
    end
    if (hreq) begin
      @(negedge clk);
      halt_req = 1'b0;
      checks++;
      if ({halted, imem_req} !== 2'b10) begin
        failures++;
        $display("FAIL halt_hold h=%b req=%b exp=1,0", halted, imem_req);
      end
      @(negedge clk);
      checks++;
      if ({halted, imem_req} !== 2'b01) begin
        failures++;
        $display("FAIL halt_release h=%b req=%b exp=0,1", halted, imem_req);
      end
    end
    halt_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    do_reset();
    checks++;
    if (imem_req !== 1'b1) begin
      failures++;
      $display("FAIL idle_to_fetch req=%b exp=1", imem_req);
    end
  endtask

  task automatic test_add();
    do_instr(32'h00430820, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (retired !== CW'(1)) begin
      failures++;
      $display("FAIL add_retired got=%0d exp=1", retired);
    end
  endtask

  task automatic test_branch();
    do_instr(32'h10220003, 0, 1'b1, 1'b0, 1'b0);
    do_instr(32'h10220003, 1, 1'b0, 1'b0, 1'b0);
    do_instr(32'h14220003, 0, 1'b0, 1'b1, 1'b0);
    do_instr(32'h28220003, 0, 1'b0, 1'b1, 1'b0);
    do_instr(32'h2c220003, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h2c220003, 0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_jump();
    do_instr(32'h08000010, 0, 1'b0, 1'b0, 1'b0);
    do_instr(32'h00200008, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_illegal();
    int saved;
    saved = exp_ret;
    do_instr(32'hFC000000, 0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      imem_ack = 1'($urandom); halt_req = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({fault, imem_req, pc_load, halted} !== 4'b1000 ||
          retired !== CW'(saved)) begin
        failures++;
        $display("FAIL fault_sticky k=%0d f=%b ret=%0d exp f=1 ret=%0d",
                 k, fault, retired, saved);
      end
    end
    do_reset();
  endtask

  task automatic test_timeout();
    do_instr(32'h00430820, 15, 1'b0, 1'b0, 1'b0);
    do_instr(32'h20010005, 10, 1'b0, 1'b0, 1'b0);
    do_instr(32'h00430822, 10, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) begin
      imem_ack = 1'b0;
      checks++;
      if ({imem_req, fault} !== 2'b10) begin
        failures++;
        $display("FAIL timeout_wait k=%0d req=%b f=%b exp=1,0", k, imem_req, fault);
      end
      @(negedge clk);
    end
    checks++;
    if ({fault, imem_req} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_fault f=%b req=%b exp=1,0", fault, imem_req);
    end
    do_reset();
  endtask

  task automatic test_halt();
    do_instr(32'h00430820, 0, 1'b0, 1'b0, 1'b1);
    do_instr(32'h08000010, 2, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0; halt_req = 1'b1;
    @(negedge clk);
    reset = 1'b1; exp_ret = 0;
    @(negedge clk);
    checks++;
    if ({halted, imem_req} !== 2'b10) begin
      failures++;
      $display("FAIL idle_halt h=%b req=%b exp=1,0", halted, imem_req);
    end
    halt_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({halted, imem_req} !== 2'b01) begin
      failures++;
      $display("FAIL idle_halt_release h=%b req=%b exp=0,1", halted, imem_req);
    end
  endtask

  task automatic test_reset_mid();
    do_instr(32'h00430820, 0, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h00430824;
    @(negedge clk);
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_write, pc_load} !== 2'b11) begin
      failures++;
      $display("FAIL mid_wb rw=%b pl=%b exp=1,1", reg_write, pc_load);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req, alu_src, alu_op, reg_write, pc_load, pc_sel,
         halted, fault, retired, ir} !== '0) begin
      failures++;
      $display("FAIL mid_reset rw=%b pl=%b op=%0d ret=%0d ir=%h exp=all0",
               reg_write, pc_load, alu_op, retired, ir);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < (1 << CW); i++) begin
      do_instr(gen(1'b0), $urandom_range(0, 2), 1'($urandom), 1'($urandom), 1'b0);
    end
    checks++;
    if (retired !== CW'(0)) begin
      failures++;
      $display("FAIL wrap got=%0d exp=0", retired);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int i = 0; i < 80; i++) begin
      w = gen(1'b1);
      do_instr(w, $urandom_range(0, 6), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 7) == 0));
      if (fault === 1'b1) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
